// File: rtl/mult_pipe_pkg.sv
// rtl/mult_pipe_pkg.sv - shared mode/stage constants and latency helper for mult_pipe
package mult_pipe_pkg;

    localparam logic [63:0] S_REGISTER = 64'("REGISTER");
    localparam logic [63:0] S_BYPASS   = 64'("BYPASS");
    localparam logic [63:0] S_MULT     = 64'("MULT");
    localparam logic [63:0] S_MAC      = 64'("MAC");

    function automatic int mult_latency(input logic [63:0] reg_a,
                                        input logic [63:0] reg_b,
                                        input logic [63:0] reg_out,
                                        input logic [63:0] mode);
        int ni;
        ni = (reg_a == S_REGISTER || reg_b == S_REGISTER) ? 1 : 0;
        if (mode == S_MAC) return ni + 1;
        return ni + ((reg_out == S_REGISTER) ? 1 : 0);
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// rtl/mult_pipe_stage.sv - optional pipeline register with clock enable and async active-low reset
module mult_pipe_stage
    import mult_pipe_pkg::*;
#(
    parameter int          WIDTH    = 1,
    parameter logic [63:0] MODE_REG = S_REGISTER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (MODE_REG == S_REGISTER) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (ce) begin
                    q <= d;
                end
            end
        end else begin : g_byp
            logic unused_ctl;
            assign unused_ctl = &{1'b0, clk, rst_n, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/mult_pipe.sv
// rtl/mult_pipe.sv - pipelined signed/unsigned multiplier with optional saturating accumulate
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int          A_WIDTH   = 9,
    parameter int          B_WIDTH   = 9,
    parameter logic [63:0] REGINPUTA = S_REGISTER,
    parameter logic [63:0] REGINPUTB = S_REGISTER,
    parameter logic [63:0] REGOUTPUT = S_REGISTER,
    parameter logic [63:0] MODE      = S_MULT,
    parameter int          ACC_WIDTH = A_WIDTH + B_WIDTH + 4
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               CE,
    input  logic               VALID_IN,
    input  logic [A_WIDTH-1:0] A,
    input  logic               SIGNEDA,
    input  logic [B_WIDTH-1:0] B,
    input  logic               SIGNEDB,
    input  logic               ACC_CLR,
    output logic               VALID_OUT,
    output logic [((MODE == S_MAC) ? ACC_WIDTH : A_WIDTH + B_WIDTH)-1:0] Z,
    output logic               OVF
);

    localparam int PW = A_WIDTH + B_WIDTH;
    // The valid/clear path is registered whenever either operand is, i.e. when the
    // multiply latency with a bypassed output stage is one.
    localparam logic [63:0] REG_IN =
        (mult_latency(REGINPUTA, REGINPUTB, S_BYPASS, S_MULT) == 1) ? S_REGISTER : S_BYPASS;

    logic [A_WIDTH:0] a_s;
    logic [B_WIDTH:0] b_s;
    logic [1:0]       vc_s;

    mult_pipe_stage #(.WIDTH(A_WIDTH + 1), .MODE_REG(REGINPUTA)) u_stage_a (
        .clk(CLK), .rst_n(RSTN), .ce(CE), .d({SIGNEDA, A}), .q(a_s)
    );

    mult_pipe_stage #(.WIDTH(B_WIDTH + 1), .MODE_REG(REGINPUTB)) u_stage_b (
        .clk(CLK), .rst_n(RSTN), .ce(CE), .d({SIGNEDB, B}), .q(b_s)
    );

    mult_pipe_stage #(.WIDTH(2), .MODE_REG(REG_IN)) u_stage_vin (
        .clk(CLK), .rst_n(RSTN), .ce(CE), .d({ACC_CLR, VALID_IN}), .q(vc_s)
    );

    logic signed [A_WIDTH:0]  a_x;
    logic signed [B_WIDTH:0]  b_x;
    logic signed [PW+1:0]     full;
    logic [PW-1:0]            prod;
    logic                     sgn;

    assign a_x  = {a_s[A_WIDTH] & a_s[A_WIDTH-1], a_s[A_WIDTH-1:0]};
    assign b_x  = {b_s[B_WIDTH] & b_s[B_WIDTH-1], b_s[B_WIDTH-1:0]};
    assign full = a_x * b_x;
    assign prod = full[PW-1:0];
    assign sgn  = a_s[A_WIDTH] | b_s[B_WIDTH];

    generate
        if (MODE == S_MAC) begin : g_mac
            logic signed [PW-1:0]   prod_s;
            logic [ACC_WIDTH-1:0]   acc, ext, acc_nxt, sat_val;
            logic [ACC_WIDTH:0]     sum;
            logic                   sat, ovf, unused_mac;

            assign unused_mac = &{1'b0, full[PW+1:PW]};
            assign prod_s     = prod;
            assign ext        = sgn ? ACC_WIDTH'(prod_s) : ACC_WIDTH'(prod);

            // One guard bit detects wrap; the beat's signedness picks the limits.
            always_comb begin
                sum     = sgn ? ({acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext})
                              : ({1'b0, acc} + {1'b0, ext});
                sat     = 1'b0;
                sat_val = '1;
                if (sgn) begin
                    sat     = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
                    sat_val = {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}};
                end else begin
                    sat     = sum[ACC_WIDTH];
                end
                acc_nxt = sat ? sat_val : sum[ACC_WIDTH-1:0];
            end

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    acc <= '0;
                    ovf <= 1'b0;
                end else if (CE && vc_s[0]) begin
                    if (vc_s[1]) begin
                        acc <= ext;
                        ovf <= 1'b0;
                    end else begin
                        acc <= acc_nxt;
                        ovf <= ovf | sat;
                    end
                end
            end

            mult_pipe_stage #(.WIDTH(1), .MODE_REG(S_REGISTER)) u_stage_vout (
                .clk(CLK), .rst_n(RSTN), .ce(CE), .d(vc_s[0]), .q(VALID_OUT)
            );

            assign Z   = acc;
            assign OVF = ovf;
        end else begin : g_mult
            logic unused_mult;
            assign unused_mult = &{1'b0, vc_s[1], sgn, full[PW+1:PW]};

            // Data only loads on a valid beat so Z holds between results.
            mult_pipe_stage #(.WIDTH(PW), .MODE_REG(REGOUTPUT)) u_stage_z (
                .clk(CLK), .rst_n(RSTN), .ce(CE & vc_s[0]), .d(prod), .q(Z)
            );

            mult_pipe_stage #(.WIDTH(1), .MODE_REG(REGOUTPUT)) u_stage_vout (
                .clk(CLK), .rst_n(RSTN), .ce(CE), .d(vc_s[0]), .q(VALID_OUT)
            );

            assign OVF = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_mult_pipe.sv
// tb/tb_mult_pipe.sv - randomized and directed self-checking bench for mult_pipe
module tb_mult_pipe;
    import mult_pipe_pkg::*;

    localparam longint MASK18 = 64'h3FFFF;
    localparam longint MASK20 = 64'hFFFFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       valid_in = 1'b0;
    logic [8:0] a = '0;
    logic [8:0] b = '0;
    logic       sa = 1'b0;
    logic       sb = 1'b0;
    logic       acc_clr = 1'b0;

    logic        vout_m, ovf_m, vout_a, ovf_a, vout_c, ovf_c;
    logic [17:0] z_m, z_c;
    logic [19:0] z_a;

    int total = 0;
    int bad = 0;

    mult_pipe u_mult (
        .CLK(clk), .RSTN(rst_n), .CE(ce), .VALID_IN(valid_in),
        .A(a), .SIGNEDA(sa), .B(b), .SIGNEDB(sb), .ACC_CLR(acc_clr),
        .VALID_OUT(vout_m), .Z(z_m), .OVF(ovf_m)
    );

    mult_pipe #(.MODE(S_MAC), .ACC_WIDTH(20)) u_mac (
        .CLK(clk), .RSTN(rst_n), .CE(ce), .VALID_IN(valid_in),
        .A(a), .SIGNEDA(sa), .B(b), .SIGNEDB(sb), .ACC_CLR(acc_clr),
        .VALID_OUT(vout_a), .Z(z_a), .OVF(ovf_a)
    );

    mult_pipe #(.REGINPUTA(S_BYPASS), .REGINPUTB(S_BYPASS), .REGOUTPUT(S_BYPASS)) u_comb (
        .CLK(clk), .RSTN(rst_n), .CE(ce), .VALID_IN(valid_in),
        .A(a), .SIGNEDA(sa), .B(b), .SIGNEDB(sb), .ACC_CLR(acc_clr),
        .VALID_OUT(vout_c), .Z(z_c), .OVF(ovf_c)
    );

    initial forever #5 clk = ~clk;

    function automatic longint prod_of(input logic [8:0] av, input logic sav,
                                       input logic [8:0] bv, input logic sbv);
        longint x, y;
        x = sav ? longint'($signed(av)) : longint'(av);
        y = sbv ? longint'($signed(bv)) : longint'(bv);
        return x * y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every enabled edge records one sample; the sample taken one
    // enabled edge earlier is the one whose result is due at the outputs.
    typedef struct {
        logic   v;
        logic   clr;
        logic   sgn;
        longint p;
    } beat_t;

    beat_t  hist[$];
    beat_t  nb, ob;
    logic   exp_v = 1'b0;
    longint exp_mz = 0;
    longint exp_acc = 0;
    logic   exp_ovf = 1'b0;
    longint t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            exp_v   = 1'b0;
            exp_mz  = 0;
            exp_acc = 0;
            exp_ovf = 1'b0;
        end else if (ce) begin
            nb.v   = valid_in;
            nb.clr = acc_clr;
            nb.sgn = sa | sb;
            nb.p   = prod_of(a, sa, b, sb);
            hist.push_back(nb);
            if (hist.size() > 2) void'(hist.pop_front());
            exp_v = 1'b0;
            if (hist.size() == 2) begin
                ob    = hist[0];
                exp_v = ob.v;
                if (ob.v) begin
                    exp_mz = ob.p & MASK18;
                    if (ob.clr) begin
                        exp_acc = ob.p & MASK20;
                        exp_ovf = 1'b0;
                    end else if (ob.sgn) begin
                        t = (exp_acc >= 524288) ? exp_acc - 1048576 : exp_acc;
                        t = t + ob.p;
                        if (t > 524287) begin
                            t = 524287;
                            exp_ovf = 1'b1;
                        end else if (t < -524288) begin
                            t = -524288;
                            exp_ovf = 1'b1;
                        end
                        exp_acc = t & MASK20;
                    end else begin
                        t = exp_acc + ob.p;
                        if (t > MASK20) begin
                            t = MASK20;
                            exp_ovf = 1'b1;
                        end
                        exp_acc = t;
                    end
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #3;
        check("mult_vout", vout_m, exp_v);
        check("mult_z", z_m, exp_mz);
        check("mult_ovf", ovf_m, 0);
        check("mac_vout", vout_a, exp_v);
        check("mac_z", z_a, exp_acc);
        check("mac_ovf", ovf_a, exp_ovf);
        check("comb_vout", vout_c, valid_in);
        check("comb_z", z_c, prod_of(a, sa, b, sb) & MASK18);
    end

    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    task automatic drive(input logic v, input logic [8:0] av, input logic sav,
                         input logic [8:0] bv, input logic sbv, input logic clr);
        valid_in = v;
        a        = av;
        sa       = sav;
        b        = bv;
        sb       = sbv;
        acc_clr  = clr;
    endtask

    int vcount;

    initial begin
        repeat (3) tick();
        check("rst_mult_z", z_m, 0);
        check("rst_mult_vout", vout_m, 0);
        check("rst_mac_z", z_a, 0);
        check("rst_mac_ovf", ovf_a, 0);
        rst_n = 1'b1;
        ce    = 1'b1;

        // unsigned 255*2, result exactly two cycles later
        drive(1, 9'd255, 0, 9'd2, 0, 0);
        tick();
        check("lat_early_vout", vout_m, 0);
        drive(0, 9'd0, 0, 9'd0, 0, 0);
        tick();
        check("lat_vout", vout_m, 1);
        check("lat_z", z_m, 510);
        tick();
        check("lat_after_vout", vout_m, 0);
        check("hold_z", z_m, 510);

        // signed -1*3, then the same bits with A unsigned
        drive(1, 9'h1FF, 1, 9'd3, 1, 0);
        tick();
        drive(1, 9'h1FF, 0, 9'd3, 1, 0);
        tick();
        check("signed_z", z_m, 18'h3FFFD);
        drive(0, 9'd0, 0, 9'd0, 0, 0);
        tick();
        check("unsigned_a_z", z_m, 1533);

        // stall: CE low for three edges after the beat is captured
        drive(1, 9'd6, 0, 9'd7, 0, 0);
        tick();
        drive(0, 9'd0, 0, 9'd0, 0, 0);
        ce = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("stall_vout", vout_m, 0);
            check("stall_z", z_m, 1533);
        end
        ce = 1'b1;
        tick();
        check("stall_done_vout", vout_m, 1);
        check("stall_done_z", z_m, 42);

        // MAC 10*10 on four beats, clear on the first
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, 9'd10, 0, 9'd10, 0, i == 0);
            tick();
            if (i >= 1 && i <= 4) check("mac_run_z", z_a, 100 * i);
        end
        check("mac_run_ovf", ovf_a, 0);

        // MAC unsigned saturation, then clear with 1*1
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(1, 9'd511, 0, 9'd511, 0, i == 0);
            else if (i == 5) drive(1, 9'd1, 0, 9'd1, 0, 1);
            else drive(0, 9'd0, 0, 9'd0, 0, 0);
            tick();
            if (i == 4) begin
                check("mac_pre_sat_z", z_a, 1044484);
                check("mac_pre_sat_ovf", ovf_a, 0);
            end
            if (i == 5) begin
                check("mac_sat_z", z_a, 1048575);
                check("mac_sat_ovf", ovf_a, 1);
            end
            if (i == 6) begin
                check("mac_clr_z", z_a, 1);
                check("mac_clr_ovf", ovf_a, 0);
            end
        end

        // async reset mid-cycle with one result at the output and one in flight
        drive(1, 9'd100, 0, 9'd100, 0, 0);
        tick();
        drive(1, 9'd3, 0, 9'd5, 0, 0);
        tick();
        check("pre_rst_vout", vout_m, 1);
        drive(0, 9'd0, 0, 9'd0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mult_z", z_m, 0);
        check("async_rst_mult_vout", vout_m, 0);
        check("async_rst_mac_z", z_a, 0);
        check("async_rst_mac_ovf", ovf_a, 0);
        tick();
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vcount += int'(vout_m) + int'(vout_a);
        end
        check("post_rst_vout_count", vcount, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 2) != 0, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
                  9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
            tick();
        end
        ce = 1'b1;
        drive(0, 9'd0, 0, 9'd0, 0, 0);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_pipe.md
MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 The block SHALL expose these parameters, one per line (name, default, meaning):
- A_WIDTH, 9, operand A width (2..36).
- B_WIDTH, 9, operand B width (2..36).
- REGINPUTA, "REGISTER", "REGISTER" or "BYPASS" for the A/SIGNEDA input stage.
- REGINPUTB, "REGISTER", same as REGINPUTA, for B/SIGNEDB.
- REGOUTPUT, "REGISTER", "REGISTER" or "BYPASS" for the output stage; ignored in MAC mode.
- MODE, "MULT", "MULT" (multiply) or "MAC" (multiply-accumulate).
- ACC_WIDTH, A_WIDTH+B_WIDTH+4, accumulator width in MAC mode; SHALL be >= A_WIDTH+B_WIDTH.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- CLK  in  1  single clock; all registers on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- CE  in  1  global clock enable.
- VALID_IN  in  1  operands valid this cycle.
- A  in  A_WIDTH  operand A.
- SIGNEDA  in  1  1 = A is two's complement.
- B  in  B_WIDTH  operand B.
- SIGNEDB  in  1  1 = B is two's complement.
- ACC_CLR  in  1  MAC: load product instead of accumulating; clears OVF.
- VALID_OUT  out  1  Z holds a new result.
- Z  out  ZW  result; ZW = ACC_WIDTH in MAC mode, else A_WIDTH+B_WIDTH.
- OVF  out  1  MAC sticky saturation flag; constant 0 in MULT mode.

Function
REQ-003 Each operand SHALL be extended by one bit per its SIGNED flag (sign or zero); the product SHALL be a signed multiply truncated to A_WIDTH+B_WIDTH bits.
REQ-004 SIGNEDA SHALL travel through the A input stage and SIGNEDB through the B input stage, so each flag stays aligned with its own operand.
REQ-005 Input-stage count NI SHALL be 1 if either REGINPUTA or REGINPUTB is "REGISTER", else 0.
REQ-006 Latency from VALID_IN to VALID_OUT:
- MULT mode: NI + (REGOUTPUT=="REGISTER").
- MAC mode: NI + 1.
- All-BYPASS MULT (latency 0): the block is purely combinational and VALID_OUT = VALID_IN.
REQ-007 With mixed input registering, the bypassed operand SHALL be used as presented in the cycle the registered operand leaves its stage; no balancing register SHALL be inserted.
REQ-008 VALID SHALL propagate through a shift register of the same depth as the data path, so valid and data always stay aligned.
REQ-009 When CE=0, every register (data, sign flags, valid, accumulator, OVF) SHALL hold its value; when CE=1, registers SHALL load.
REQ-010 MULT mode: Z SHALL keep its last value while VALID_OUT=0 (output registers load only on a valid beat).
REQ-011 MAC mode, on a valid product beat with CE=1:
- ACC_CLR=1: ACC <= extended product and OVF <= 0.
- ACC_CLR=0: ACC <= ACC + extended product.
- ACC_CLR SHALL be sampled in the same stage as the product it qualifies.
REQ-012 MAC extension and saturation:
- If either SIGNED flag is set for the beat, the product SHALL be sign-extended and the sum SHALL saturate to the signed ACC_WIDTH limits.
- Otherwise the product SHALL be zero-extended and the sum SHALL saturate to 2^ACC_WIDTH-1.
- Any saturation SHALL set OVF, which stays set until a beat with ACC_CLR=1.
REQ-013 MAC mode: ACC_CLR on a non-valid beat SHALL be ignored. Z SHALL equal ACC.

Reset
REQ-014 RSTN=0 SHALL asynchronously clear all registers: Z=0, VALID_OUT=0, OVF=0, accumulator=0, valid pipeline=0.
REQ-015 Beats in flight when reset asserts SHALL be discarded. The first valid result after reset release SHALL come from the first VALID_IN sampled after release.

Structure
REQ-016 A shared package mult_pipe_pkg SHALL hold:
- the MODE and REG* string constants;
- a latency function of (REGINPUTA, REGINPUTB, REGOUTPUT, MODE).
REQ-017 One sub-module, mult_pipe_stage, SHALL implement a parametrised-width register with CE, async active-low reset and a REGISTER/BYPASS parameter. It SHALL be reused for the A, B, valid and output stages.

Verification
REQ-018 Defaults, unsigned A=255, B=2, VALID_IN pulse -> Z=510 with VALID_OUT high exactly 2 cycles later.
REQ-019 Signed A=9'h1FF (SIGNEDA=1), B=3 (SIGNEDB=1) -> Z=18'h3FFFD. The same operands with SIGNEDA=0 -> Z=1533.
REQ-020 VALID_IN at cycle 0, CE=0 for cycles 1-3 -> VALID_OUT first high at cycle 5; Z is unchanged during the stall.
REQ-021 MAC, 10*10 on four consecutive beats, ACC_CLR on the first -> Z=100, 200, 300, 400 and OVF=0.
REQ-022 MAC, ACC_WIDTH=20, unsigned 511*511 on five beats -> fifth Z=1048575 and OVF=1; a following ACC_CLR beat with 1*1 -> Z=1 and OVF=0.
REQ-023 RSTN low between clock edges while a beat is in flight -> Z=0, VALID_OUT=0 and OVF=0 immediately; no VALID_OUT after release.
